// File: rtl/map_pkg.sv
// map_pkg: map geometry, cell encodings and the {y, x} address helper shared by map RAM users.
package map_pkg;

    localparam int MAP_W   = 64;
    localparam int MAP_H   = 44;
    localparam int COORD_W = 6;
    localparam int ADDR_W  = 2 * COORD_W;

    localparam logic CELL_EMPTY = 1'b0;
    localparam logic CELL_WALL  = 1'b1;

    typedef logic [ADDR_W-1:0] map_addr_t;

    function automatic map_addr_t map_addr(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
        return {y, x};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one grant per enabled cycle, searching from the slot after the last winner.
module rr_arbiter #(
    parameter int N = 3,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  i_elig,
    input  logic          i_en,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_gnt_idx
);

    logic [IW-1:0] ptr;
    logic [IW-1:0] cand;
    logic          found;

    always_comb begin
        o_gnt_idx = '0;
        cand      = '0;
        found     = 1'b0;
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(ptr) + k) % N);
            if (!found && i_elig[cand]) begin
                found     = 1'b1;
                o_gnt_idx = cand;
            end
        end
        o_gnt = (found && i_en) ? ({{(N-1){1'b0}}, 1'b1} << o_gnt_idx) : '0;
    end

    // Pointer starts at N-1 so requester 0 is the first winner after reset.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            ptr <= IW'(N - 1);
        else if (|o_gnt)
            ptr <= o_gnt_idx;

endmodule

// File: rtl/map_access_arbiter.sv
// map_access_arbiter: VGA owns the map RAM during active display; game requesters share it
// round-robin during blanking, one transaction per cycle.
module map_access_arbiter
    import map_pkg::map_addr_t;
    import map_pkg::map_addr;
    import map_pkg::CELL_WALL;
#(
    parameter int N_REQ  = 3,
    parameter int MAP_W  = 64,
    parameter int MAP_H  = 44,
    parameter int DATA_W = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_vga_busy,
    input  logic [5:0]              i_vga_x,
    input  logic [5:0]              i_vga_y,
    output logic [DATA_W-1:0]       o_vga_cell,
    input  logic [N_REQ-1:0]        i_req,
    input  logic [N_REQ-1:0]        i_we,
    input  logic [N_REQ*6-1:0]      i_x,
    input  logic [N_REQ*6-1:0]      i_y,
    input  logic [N_REQ*DATA_W-1:0] i_wdata,
    output logic [N_REQ-1:0]        o_ack,
    output logic [DATA_W-1:0]       o_rdata,
    output logic                    o_vblank_start,
    output logic [11:0]             o_ram_addr,
    output logic                    o_ram_we,
    output logic [DATA_W-1:0]       o_ram_wdata,
    input  logic [DATA_W-1:0]       i_ram_rdata
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [DATA_W-1:0] WALL = {DATA_W{CELL_WALL}};

    logic [N_REQ-1:0]  elig;
    logic [N_REQ-1:0]  gnt;
    logic [IW-1:0]     gnt_idx;
    logic [5:0]        gx;
    logic [5:0]        gy;
    logic              g_we;
    logic [DATA_W-1:0] g_wdata;
    logic              g_oor;
    logic              vga_oor;
    map_addr_t         ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic              busy_q;
    logic              pend_oor_q;
    logic              vga_pend_q;
    logic              vga_oor_q;
    logic [DATA_W-1:0] rdata_q;

    // A requester in its ack cycle sits out so it can present its next transaction.
    assign elig = i_req & ~o_ack;

    rr_arbiter #(.N(N_REQ)) u_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_elig    (elig),
        .i_en      (!i_vga_busy),
        .o_gnt     (gnt),
        .o_gnt_idx (gnt_idx)
    );

    assign gx      = i_x[int'(gnt_idx)*6 +: 6];
    assign gy      = i_y[int'(gnt_idx)*6 +: 6];
    assign g_we    = i_we[gnt_idx];
    assign g_wdata = i_wdata[int'(gnt_idx)*DATA_W +: DATA_W];
    assign g_oor   = (int'(gx) >= MAP_W) || (int'(gy) >= MAP_H);
    assign vga_oor = (int'(i_vga_x) >= MAP_W) || (int'(i_vga_y) >= MAP_H);

    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (i_vga_busy)
            ram_addr = map_addr(i_vga_x, i_vga_y);
        else if (|gnt && !g_oor) begin
            ram_addr  = map_addr(gx, gy);
            ram_we    = g_we;
            ram_wdata = g_wdata;
        end
    end

    // The RAM port is combinational from the grant, so it is forced idle while reset is held.
    assign o_ram_addr  = rst_n ? ram_addr : '0;
    assign o_ram_we    = rst_n && ram_we;
    assign o_ram_wdata = rst_n ? ram_wdata : '0;

    assign o_rdata = (|o_ack) ? (pend_oor_q ? WALL : i_ram_rdata) : rdata_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            busy_q         <= 1'b0;
            o_vblank_start <= 1'b0;
            o_ack          <= '0;
            pend_oor_q     <= 1'b0;
            rdata_q        <= '0;
            vga_pend_q     <= 1'b0;
            vga_oor_q      <= 1'b0;
            o_vga_cell     <= '0;
        end else begin
            busy_q         <= i_vga_busy;
            o_vblank_start <= busy_q && !i_vga_busy;
            o_ack          <= gnt;
            pend_oor_q     <= g_oor;
            if (|o_ack)
                rdata_q <= o_rdata;
            vga_pend_q     <= i_vga_busy;
            vga_oor_q      <= vga_oor;
            if (vga_pend_q)
                o_vga_cell <= vga_oor_q ? WALL : i_ram_rdata;
        end

endmodule

// File: tb/tb_map_access_arbiter.sv
// tb_map_access_arbiter: directed checks of VGA priority, round-robin, range checks, busy edges and reset.
module tb_map_access_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_vga_busy;
    logic [5:0]  i_vga_x, i_vga_y;
    logic [0:0]  o_vga_cell;
    logic [2:0]  i_req, i_we;
    logic [17:0] i_x, i_y;
    logic [2:0]  i_wdata;
    logic [2:0]  o_ack;
    logic [0:0]  o_rdata;
    logic        o_vblank_start;
    logic [11:0] o_ram_addr;
    logic        o_ram_we;
    logic [0:0]  o_ram_wdata;
    logic [0:0]  i_ram_rdata;

    logic [0:0]  mem [4096];
    int          checks = 0;
    int          failures = 0;
    int          we_cnt = 0;
    int          we_base;

    map_access_arbiter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_vga_busy     (i_vga_busy),
        .i_vga_x        (i_vga_x),
        .i_vga_y        (i_vga_y),
        .o_vga_cell     (o_vga_cell),
        .i_req          (i_req),
        .i_we           (i_we),
        .i_x            (i_x),
        .i_y            (i_y),
        .i_wdata        (i_wdata),
        .o_ack          (o_ack),
        .o_rdata        (o_rdata),
        .o_vblank_start (o_vblank_start),
        .o_ram_addr     (o_ram_addr),
        .o_ram_we       (o_ram_we),
        .o_ram_wdata    (o_ram_wdata),
        .i_ram_rdata    (i_ram_rdata)
    );

    always #5 clk = ~clk;

    // Single-port RAM with read-before-write and one cycle of read latency.
    always @(posedge clk) begin
        if (o_ram_we) begin
            mem[o_ram_addr] <= o_ram_wdata;
            we_cnt <= we_cnt + 1;
        end
        i_ram_rdata <= mem[o_ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] rr_ack [6] = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};
        logic       rr_rd  [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4096; i++) mem[i] = 1'b0;
        mem[323] = 1'b1;
        mem[65]  = 1'b1;
        mem[67]  = 1'b1;
        i_ram_rdata = 1'b0;
        rst_n = 1'b0;
        i_vga_busy = 1'b0; i_vga_x = '0; i_vga_y = '0;
        i_req = '0; i_we = '0; i_x = '0; i_y = '0; i_wdata = '0;
        #1;
        check("rst_ack", o_ack, 0);
        check("rst_rdata", o_rdata, 0);
        check("rst_vga_cell", o_vga_cell, 0);
        check("rst_vblank", o_vblank_start, 0);
        check("rst_ram_we", o_ram_we, 0);
        check("rst_ram_addr", o_ram_addr, 0);
        check("rst_ram_wdata", o_ram_wdata, 0);
        tick();
        rst_n = 1'b1;
        i_vga_busy = 1'b1; i_vga_x = 6'd3; i_vga_y = 6'd5;
        i_req = 3'b001;
        #1;
        check("vga_addr", o_ram_addr, 323);
        check("vga_we", o_ram_we, 0);
        tick();
        check("vga_busy_ack1", o_ack, 0);
        check("vga_cell_t1", o_vga_cell, 0);
        tick();
        check("vga_cell_t2", o_vga_cell, 1);
        check("vga_busy_ack2", o_ack, 0);
        i_vga_busy = 1'b0;
        tick();
        check("vblank_pulse", o_vblank_start, 1);
        check("first_ack", o_ack, 3'b001);
        check("first_rdata", o_rdata, 0);
        i_req = 3'b000;
        tick();
        check("vblank_once", o_vblank_start, 0);
        check("ack_clear", o_ack, 0);
        i_req = 3'b111;
        i_x = {6'd3, 6'd2, 6'd1};
        i_y = {6'd1, 6'd1, 6'd1};
        for (int i = 0; i < 6; i++) begin
            tick();
            check("rr_ack", o_ack, rr_ack[i]);
            check("rr_rdata", o_rdata, rr_rd[i]);
        end
        i_req = 3'b010; i_we = 3'b010;
        i_x = {6'd0, 6'd10, 6'd0}; i_y = {6'd0, 6'd20, 6'd0}; i_wdata = 3'b010;
        #1;
        check("wr_ram_we", o_ram_we, 1);
        check("wr_ram_addr", o_ram_addr, 1290);
        check("wr_ram_wdata", o_ram_wdata, 1);
        tick();
        check("wr_ack", o_ack, 3'b010);
        i_req = 3'b100; i_we = 3'b000; i_wdata = 3'b000;
        i_x = {6'd10, 6'd0, 6'd0}; i_y = {6'd20, 6'd0, 6'd0};
        tick();
        check("rd_ack", o_ack, 3'b100);
        check("rd_rdata", o_rdata, 1);
        i_req = 3'b000;
        tick();
        check("rd_idle_ack", o_ack, 0);
        check("rd_hold", o_rdata, 1);
        we_base = we_cnt;
        i_req = 3'b001; i_x = '0; i_y = {6'd0, 6'd0, 6'd44};
        #1;
        check("oor_rd_we", o_ram_we, 0);
        tick();
        check("oor_rd_ack", o_ack, 3'b001);
        check("oor_rd_data", o_rdata, 1);
        i_we = 3'b001; i_x = {6'd0, 6'd0, 6'd63}; i_y = {6'd0, 6'd0, 6'd50}; i_wdata = 3'b001;
        tick();
        check("oor_gap_ack", o_ack, 0);
        tick();
        check("oor_wr_ack", o_ack, 3'b001);
        check("oor_we_cnt", we_cnt, we_base);
        check("oor_mem", mem[3263], 0);
        i_req = 3'b010; i_we = 3'b000; i_wdata = 3'b000;
        i_x = {6'd0, 6'd2, 6'd1}; i_y = {6'd0, 6'd1, 6'd1};
        tick();
        check("inflight_ack", o_ack, 3'b010);
        check("inflight_rdata", o_rdata, 0);
        i_vga_busy = 1'b1; i_vga_x = 6'd0; i_vga_y = 6'd0;
        i_req = 3'b011;
        tick();
        check("busy_no_grant1", o_ack, 0);
        tick();
        check("busy_no_grant2", o_ack, 0);
        check("vga_cell_zero", o_vga_cell, 0);
        i_vga_y = 6'd44;
        tick();
        check("busy_no_grant3", o_ack, 0);
        tick();
        check("vga_oor_cell", o_vga_cell, 1);
        i_vga_busy = 1'b0;
        tick();
        check("vblank_pulse2", o_vblank_start, 1);
        check("post_busy_ack", o_ack, 3'b001);
        check("post_busy_rdata", o_rdata, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ack", o_ack, 0);
        check("arst_vblank", o_vblank_start, 0);
        check("arst_rdata", o_rdata, 0);
        check("arst_vga_cell", o_vga_cell, 0);
        check("arst_ram_we", o_ram_we, 0);
        check("arst_ram_addr", o_ram_addr, 0);
        tick();
        rst_n = 1'b1;
        #1;
        check("rel_grant_addr", o_ram_addr, 65);
        tick();
        check("rel_first_ack", o_ack, 3'b001);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/map_access_arbiter.md
# map_access_arbiter

Shares the single-port map RAM between the VGA renderer's cell lookups and the game-logic requesters, such as tank movement, shell collision and brick destruction. During active display the VGA path owns the RAM every cycle. During vertical blanking the game requesters are served round-robin. Game-side writes are therefore confined to blanking, which keeps every frame tear-free. The block sits between the VGA block, the game FSM and the map RAM.

## Interface
- `N_REQ`, 3: number of game-side requesters.
- `MAP_W`, 64: map width in cells; the x coordinate is 6 bits.
- `MAP_H`, 44: playable map height in cells; the y coordinate is 6 bits.
- `DATA_W`, 1: cell data width (1 = wall).
- Reset: rst_n, asynchronous, active-low. Clock: clk.
- `clk`  in  1  system/pixel clock.
- `rst_n`  in  1  async active-low reset.
- `i_vga_busy`  in  1  VGA is in active-display lines.
- `i_vga_x`, `i_vga_y`  in  6 each  VGA cell lookup coordinate.
- `o_vga_cell`  out  `DATA_W`  cell data for the VGA lookup.
- `i_req`  in  `N_REQ`  per-requester request.
- `i_we`  in  `N_REQ`  per-requester write enable.
- `i_x`, `i_y`  in  `N_REQ`×6 each  packed per-requester coordinates.
- `i_wdata`  in  `N_REQ`×`DATA_W`  packed write data.
- `o_ack`  out  `N_REQ`  one-cycle completion pulse.
- `o_rdata`  out  `DATA_W`  read data, valid with `o_ack`.
- `o_vblank_start`  out  1  one-cycle pulse on the falling edge of `i_vga_busy`.
- `o_ram_addr`  out  12  RAM address, computed as {y, x}.
- `o_ram_we`  out  1  RAM write enable.
- `o_ram_wdata`  out  `DATA_W`  RAM write data.
- `i_ram_rdata`  in  `DATA_W`  RAM read data, 1-cycle latency.

## Operation
**Address source**
- `i_vga_busy`=1: the RAM address is {`i_vga_y`, `i_vga_x`} with `o_ram_we`=0. No game grant is issued.
- `i_vga_busy`=0: one grant per cycle. Round-robin starts from (last granted + 1) mod `N_REQ`; the last-granted pointer resets to `N_REQ`-1, so requester 0 wins first.
- Eligibility: a requester is eligible when `i_req`=1 and it is not in its ack cycle.

**Requester handshake**
- Requester holds `req`, `we`, `x`, `y` and `wdata` stable until it sees `o_ack`.
- In the cycle after ack it either drops `req` or presents a new transaction.

**Address checks**
- A coordinate is out of range when x ≥ `MAP_W` or y ≥ `MAP_H`.
- Out-of-range read returns all-ones (the border is a wall); the RAM is not accessed.
- Out-of-range write is dropped but still acked.
- Out-of-range VGA lookup returns all-ones.

**In-flight transactions**
- A game grant whose busy rises in the next cycle still completes. The ack cycle needs no RAM port.

**Reset values**
- `o_ack`=0, `o_rdata`=0, `o_vga_cell`=0, `o_vblank_start`=0.
- `o_ram_we`=0, `o_ram_addr`=0, `o_ram_wdata`=0.
- RR pointer = `N_REQ`-1.
- `i_vga_busy` history = 0.

**Reset mid-transaction**
- The pending ack is discarded.
- A write registered in the grant cycle may or may not have reached the RAM; the game FSM re-inits the map after reset.

## Timing
- **Grant cycle t:** the RAM port (`o_ram_addr`, `o_ram_we`, `o_ram_wdata`) is driven combinationally from the granted requester.
- **Cycle t+1:**
  - `o_ack[g]`=1 for the granted requester.
  - `o_rdata` = `i_ram_rdata`, or all-ones when out of range.
  - `o_rdata` is registered at end of t+1 and held until the next ack.
- **VGA lookup:** coordinate at cycle t gives `o_vga_cell` at t+2 (RAM latency plus output register). The VGA request-ahead offset accounts for this.
- **Blanking throughput:** one transaction per cycle across requesters. A single requester achieves one transaction per 2 cycles.
- **`o_vblank_start`:** asserted in the cycle after `i_vga_busy` is sampled 1→0.
- **Simultaneous events:** busy rising in the same cycle as a request means no grant; busy wins.

## Structure
- Package `map_pkg` holds:
  - `MAP_W`, `MAP_H` and the cell-type constants (`CELL_EMPTY`, `CELL_WALL`).
  - `map_addr_t` (12 bits) and the function `map_addr(x, y)`.
- Sub-module `rr_arbiter`:
  - Parameter `N`.
  - Inputs: eligible vector, enable, clk, rst_n.
  - Outputs: one-hot grant and grant index; owns the pointer.

## Test plan
- **VGA priority:** `i_vga_busy`=1, VGA (3,5), RAM[{5,3}]=1, requester 0 reading (0,0) → `o_vga_cell`=1 two cycles later; `o_ack` stays 0 until busy falls.
- **Round-robin:** busy=0, all three requesting reads every cycle → acks rotate 0,1,2,0,…; no requester acked twice within 3 cycles.
- **Write then read:** requester 1 writes (10,20)=1, then requester 2 reads (10,20) → `o_rdata`=1 on its ack.
- **Out of range:** read (0,44) → ack with `o_rdata`=1, `o_ram_we` never asserted. Write (63,50) → acked, RAM unchanged.
- **Busy edges:** busy falls → `o_vblank_start` pulses exactly once. Busy rises one cycle after a grant → that ack still arrives and no new grant follows.
- **Reset:** `rst_n` low during the ack cycle → all outputs 0 asynchronously. After release, requester 0 is granted first.
